// File: rtl/key_pkg.sv
// key_pkg: scan-code constants, action indices, channel FSM states and
// small decode helpers shared by key_chan and key_action_gen.
// Optional feature macro used by the design: KEY_REPEAT_EN (auto-repeat).
`timescale 1ns/1ps
package key_pkg;

    // Player-1 scan codes, one per action bit
    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_A     = 8'h29;
    localparam logic [7:0] SC_P1_B     = 8'h5A;

    // Player-2 scan codes, one per action bit
    localparam logic [7:0] SC_P2_UP    = 8'h1D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h1B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h1C;
    localparam logic [7:0] SC_P2_RIGHT = 8'h23;
    localparam logic [7:0] SC_P2_A     = 8'h12;
    localparam logic [7:0] SC_P2_B     = 8'h14;

    // Escape is shared by both players
    localparam logic [7:0] SC_ESC      = 8'h76;

    // Action bit positions inside o_pX_act
    localparam int ACT_UP    = 0;
    localparam int ACT_DOWN  = 1;
    localparam int ACT_LEFT  = 2;
    localparam int ACT_RIGHT = 3;
    localparam int ACT_A     = 4;
    localparam int ACT_B     = 5;
    localparam int N_ACT     = 6;

    // Decoded key: 0..5 action index, plus two special values
    typedef logic [2:0] act_idx_t;
    localparam act_idx_t IDX_ESC  = 3'd6;
    localparam act_idx_t IDX_NONE = 3'd7;

    // Code maps: code for action i sits in bits [8*i +: 8]
    localparam logic [8*N_ACT-1:0] P1_MAP = {SC_P1_B, SC_P1_A, SC_P1_RIGHT,
                                            SC_P1_LEFT, SC_P1_DOWN, SC_P1_UP};
    localparam logic [8*N_ACT-1:0] P2_MAP = {SC_P2_B, SC_P2_A, SC_P2_RIGHT,
                                            SC_P2_LEFT, SC_P2_DOWN, SC_P2_UP};

    // Repeat counter geometry
    localparam int                CNT_W   = 24;
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    // Per-player channel FSM
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS    = 2'd1,
        ST_HOLD_DLY = 2'd2,
        ST_REPEAT   = 2'd3
    } key_state_e;

    // Translate a held code into an action index using a player's map
    function automatic act_idx_t decode_key(input logic [7:0]         code,
                                            input logic [8*N_ACT-1:0] map);
        act_idx_t idx;
        idx = IDX_NONE;
        if (code == SC_ESC) begin
            idx = IDX_ESC;
        end else if (code != 8'h00) begin
            for (int i = 0; i < N_ACT; i++) begin
                if (map[8*i +: 8] == code) begin
                    idx = act_idx_t'(i);
                end
            end
        end
        return idx;
    endfunction

    // Only the movement keys down/left/right auto-repeat
    function automatic logic is_repeatable(input act_idx_t idx);
        return (idx == act_idx_t'(ACT_DOWN)) || (idx == act_idx_t'(ACT_LEFT)) ||
               (idx == act_idx_t'(ACT_RIGHT));
    endfunction

    // Saturating increment for the repeat counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/key_action_gen_if.sv
// key_action_gen_if: held-key inputs from the PS/2 side and the action
// pulse outputs. master = stimulus/keyboard side, slave = key_action_gen.
// Optional feature macro affecting the design: KEY_REPEAT_EN.
`timescale 1ns/1ps
interface key_action_gen_if;
    logic [7:0] i_key_p1;
    logic [7:0] i_key_p2;
    logic [5:0] o_p1_act;
    logic [5:0] o_p2_act;
    logic       o_esc;

    modport master (
        output i_key_p1, i_key_p2,
        input  o_p1_act, o_p2_act, o_esc
    );

    modport slave (
        input  i_key_p1, i_key_p2,
        output o_p1_act, o_p2_act, o_esc
    );
endinterface

// File: rtl/key_chan.sv
// key_chan: one player's path -- two-flop synchronizer, stability filter,
// press/repeat FSM and registered one-cycle action pulses.
// With KEY_REPEAT_EN defined, down/left/right auto-repeat after a delay;
// without it only press pulses are generated.
`timescale 1ns/1ps
module key_chan
    import key_pkg::*;
#(
    parameter int                 STABLE_CYC    = 4,
    parameter logic [8*N_ACT-1:0] CODE_MAP      = P1_MAP
`ifdef KEY_REPEAT_EN
   ,parameter int                 REPEAT_DELAY  = 12_500_000,
    parameter int                 REPEAT_PERIOD = 2_500_000
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_key,
    output logic [5:0] o_act,
    output logic       o_esc
);

    localparam int FC_W = $clog2(STABLE_CYC + 1);

    logic [7:0]      sync1_q, sync2_q;
    logic [7:0]      filt_prev_q;
    logic [FC_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [7:0]      key_acc_q;

    key_state_e      state_q, state_d;
    logic [7:0]      held_q, held_d;
    act_idx_t        acc_idx, held_idx, pulse_idx;
    logic [5:0]      act_q, act_d;
    logic            esc_q;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_CNT = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PER_CNT = CNT_W'(REPEAT_PERIOD);
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    // Length of the current run of equal synchronized samples, saturating
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        if (sync2_q != filt_prev_q) begin
            filt_cnt_d = FC_W'(1);
        end else if (filt_cnt_q < FC_W'(STABLE_CYC)) begin
            filt_cnt_d = filt_cnt_q + FC_W'(1);
        end
    end

    // Synchronizer, filter run tracking and acceptance of a stable code
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_prev_q <= '0;
            filt_cnt_q  <= '0;
            key_acc_q   <= '0;
        end else begin
            sync1_q     <= i_key;
            sync2_q     <= sync1_q;
            filt_prev_q <= sync2_q;
            filt_cnt_q  <= filt_cnt_d;
            if (filt_cnt_d == FC_W'(STABLE_CYC)) begin
                key_acc_q <= sync2_q;
            end
        end
    end

    assign acc_idx  = decode_key(key_acc_q, CODE_MAP);
    assign held_idx = decode_key(held_q, CODE_MAP);

    // Next state, pulse request and repeat counter
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        pulse_idx = IDX_NONE;
`ifdef KEY_REPEAT_EN
        rpt_cnt_d = sat_inc(rpt_cnt_q);
`endif
        if (acc_idx == IDX_NONE) begin
            // released or unmapped: silent return to idle
            state_d = ST_IDLE;
            held_d  = key_acc_q;
`ifdef KEY_REPEAT_EN
            rpt_cnt_d = '0;
`endif
        end else if (key_acc_q != held_q) begin
            // new mapped code: fresh press, counter restarts from the press
            state_d = ST_PRESS;
            held_d  = key_acc_q;
`ifdef KEY_REPEAT_EN
            rpt_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                ST_PRESS: begin
                    pulse_idx = held_idx;
`ifdef KEY_REPEAT_EN
                    state_d = is_repeatable(held_idx) ? ST_HOLD_DLY : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
`ifdef KEY_REPEAT_EN
                ST_HOLD_DLY: begin
                    if (rpt_cnt_q >= DLY_CNT) begin
                        pulse_idx = held_idx;
                        state_d   = ST_REPEAT;
                        rpt_cnt_d = CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (rpt_cnt_q >= PER_CNT) begin
                        pulse_idx = held_idx;
                        rpt_cnt_d = CNT_W'(1);
                    end
                end
`endif
                default: begin
                    // idle while a key stays held: wait for a code change
                    state_d = ST_IDLE;
`ifdef KEY_REPEAT_EN
                    rpt_cnt_d = '0;
`endif
                end
            endcase
        end
    end

    // One-hot action vector from the pulse request (at most one bit)
    always_comb begin
        act_d = '0;
        for (int i = 0; i < N_ACT; i++) begin
            act_d[i] = (pulse_idx == act_idx_t'(i));
        end
    end

    // FSM state, held code, counter and registered pulse outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
            act_q   <= '0;
            esc_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            act_q   <= act_d;
            esc_q   <= (pulse_idx == IDX_ESC);
`ifdef KEY_REPEAT_EN
            rpt_cnt_q <= rpt_cnt_d;
`endif
        end
    end

    assign o_act = act_q;
    assign o_esc = esc_q;

endmodule

// File: rtl/key_action_gen.sv
// key_action_gen: two-player keyboard action pulse generator. One key_chan
// per player; escape from either player merges into a single o_esc pulse.
// Optional feature macro: KEY_REPEAT_EN enables auto-repeat of down/left/right.
`timescale 1ns/1ps
module key_action_gen
    import key_pkg::*;
#(
    parameter int STABLE_CYC    = 4,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    key_action_gen_if.slave bus
);

    logic esc_p1, esc_p2;

    // Reject configurations that cannot produce a sane pulse train
    if (STABLE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("key_action_gen: STABLE_CYC, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    key_chan #(
        .STABLE_CYC    (STABLE_CYC),
        .CODE_MAP      (P1_MAP)
`ifdef KEY_REPEAT_EN
       ,.REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan_p1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key   (bus.i_key_p1),
        .o_act   (bus.o_p1_act),
        .o_esc   (esc_p1)
    );

    key_chan #(
        .STABLE_CYC    (STABLE_CYC),
        .CODE_MAP      (P2_MAP)
`ifdef KEY_REPEAT_EN
       ,.REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan_p2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key   (bus.i_key_p2),
        .o_act   (bus.o_p2_act),
        .o_esc   (esc_p2)
    );

    // Simultaneous escapes from both players collapse to one pulse
    assign bus.o_esc = esc_p1 | esc_p2;

endmodule

// File: tb/tb_key_action_gen.sv
// tb_key_action_gen: scoreboard bench for key_action_gen. Expected pulses
// are queued when a key is driven and matched against DUT output pulses.
// Auto-repeat expectations are included only when KEY_REPEAT_EN is defined.
`timescale 1ns/1ps
module tb_key_action_gen;

    localparam int STABLE = 4;
    localparam int DLY    = 20;
    localparam int PER    = 5;
    localparam int LAT    = STABLE + 3;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    key_action_gen_if bus();

    key_action_gen #(
        .STABLE_CYC    (STABLE),
        .REPEAT_DELAY  (DLY),
        .REPEAT_PERIOD (PER)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    // Rising-edge count; a value driven at a negedge is first sampled at cyc+1
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] p1;
        logic [5:0] p2;
        logic       esc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [5:0] p1, input logic [5:0] p2, input logic esc);
        exp_t e;
        e.cyc = c; e.p1 = p1; e.p2 = p2; e.esc = esc;
        exp_q.push_back(e);
    endtask

    // Per-negedge monitor: reset quietness, missed pulses, pulse matching
    task automatic mon();
        exp_t e;
        if (!i_rst_n) begin
            chk("rst_outputs", 32'({bus.o_p1_act, bus.o_p2_act, bus.o_esc}), 32'd0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("missed_pulse", 32'(cyc), 32'(e.cyc));
            end
            if (bus.o_p1_act != 6'd0 || bus.o_p2_act != 6'd0 || bus.o_esc) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", 32'({bus.o_p1_act, bus.o_p2_act, bus.o_esc}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] pulse cyc=%0d p1=%b p2=%b esc=%b", cyc,
                             bus.o_p1_act, bus.o_p2_act, bus.o_esc);
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    chk("p1_act", 32'(bus.o_p1_act), 32'(e.p1));
                    chk("p2_act", 32'(bus.o_p2_act), 32'(e.p2));
                    chk("esc", 32'(bus.o_esc), 32'(e.esc));
                end
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge i_clk);
            mon();
        end
    endtask

    task automatic tick_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic drive(input logic [7:0] k1, input logic [7:0] k2);
        bus.i_key_p1 = k1;
        bus.i_key_p2 = k2;
    endtask

    initial begin
        int t0;
        drive(8'h00, 8'h00);

        // reset: outputs held low
        tick(3);
        i_rst_n = 1'b1;
        tick(10);

        // left held 10 cycles: single pulse LAT+1 edges after drive
        drive(8'h6B, 8'h00);
        push(cyc + 1 + LAT, 6'b000100, 6'd0, 1'b0);
        tick(10);
        drive(8'h00, 8'h00);
        tick(25);

        // P2 act_a held 100 cycles: one pulse, never repeats
        drive(8'h00, 8'h12);
        push(cyc + 1 + LAT, 6'd0, 6'b010000, 1'b0);
        tick(100);
        drive(8'h00, 8'h00);
        tick(20);

        // P1 down held: press, then repeats at +DLY and every PER
        drive(8'h72, 8'h00);
        t0 = cyc + 1 + LAT;
        push(t0, 6'b000010, 6'd0, 1'b0);
`ifdef KEY_REPEAT_EN
        push(t0 + DLY,           6'b000010, 6'd0, 1'b0);
        push(t0 + DLY + PER,     6'b000010, 6'd0, 1'b0);
        push(t0 + DLY + 2 * PER, 6'b000010, 6'd0, 1'b0);
        push(t0 + DLY + 3 * PER, 6'b000010, 6'd0, 1'b0);
        push(t0 + DLY + 4 * PER, 6'b000010, 6'd0, 1'b0);
`endif
        tick_until(t0 + 37);
        drive(8'h00, 8'h00);
        tick(25);

        // short glitch to an unmapped value: nothing accepted
        drive(8'h7F, 8'h00);
        tick(2);
        drive(8'h00, 8'h00);
        tick(20);

        // both players press esc together: one esc pulse, no actions
        drive(8'h76, 8'h76);
        push(cyc + 1 + LAT, 6'd0, 6'd0, 1'b1);
        tick(10);
        drive(8'h00, 8'h00);
        tick(20);

        // direct change up -> right produces a second press
        drive(8'h75, 8'h00);
        push(cyc + 1 + LAT, 6'b000001, 6'd0, 1'b0);
        tick(15);
        drive(8'h74, 8'h00);
        push(cyc + 1 + LAT, 6'b001000, 6'd0, 1'b0);
        tick(10);
        drive(8'h00, 8'h00);
        tick(20);

        // both players at once, different actions
        drive(8'h5A, 8'h1D);
        push(cyc + 1 + LAT, 6'b100000, 6'b000001, 1'b0);
        tick(10);
        drive(8'h00, 8'h00);
        tick(20);

        // steady unmapped code: silent
        drive(8'h00, 8'h33);
        tick(20);
        drive(8'h00, 8'h00);
        tick(20);

        // reset in the middle of repeating, key kept held through release
        drive(8'h72, 8'h00);
        t0 = cyc + 1 + LAT;
        push(t0, 6'b000010, 6'd0, 1'b0);
`ifdef KEY_REPEAT_EN
        push(t0 + DLY,       6'b000010, 6'd0, 1'b0);
        push(t0 + DLY + PER, 6'b000010, 6'd0, 1'b0);
`endif
        tick_until(t0 + 27);
        i_rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({bus.o_p1_act, bus.o_p2_act, bus.o_esc}), 32'd0);
        tick(3);
        i_rst_n = 1'b1;
        push(cyc + 1 + LAT, 6'b000010, 6'd0, 1'b0);
        tick(12);
        drive(8'h00, 8'h00);
        tick(25);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net in case the stimulus sequence ever stalls
    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, want finish before 200us");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_action_gen.md
KEY_ACTION_GEN -- requirements
Module: key_action_gen

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4: consecutive equal synchronized samples needed to accept a new held-key code.
REQ-002 SHALL have parameter REPEAT_DELAY, default 12_500_000: i_clk cycles from the press pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 2_500_000: i_clk cycles between auto-repeat pulses.
REQ-004 SHALL have port i_clk, input, 1: system clock; all logic rising-edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_key_p1, input, 8: player-1 held scan code, 0 = none; asynchronous to i_clk (PS/2 clock domain).
REQ-007 SHALL have port i_key_p2, input, 8: player-2 held scan code, 0 = none; asynchronous to i_clk.
REQ-008 SHALL have port o_p1_act, output, 6: player-1 one-cycle action pulses [0]up [1]down [2]left [3]right [4]act_a [5]act_b.
REQ-009 SHALL have port o_p2_act, output, 6: player-2 action pulses, same bit order.
REQ-010 SHALL have port o_esc, output, 1: one-cycle pulse on an esc press from either player.

Function
REQ-011 SHALL map P1 codes 75/72/6B/74/29/5A (hex) to bits 0-5 and P2 codes 1D/1B/1C/23/12/14 to bits 0-5; 76 = esc; every other nonzero code is unmapped.
REQ-012 SHALL pass each input through a two-flop synchronizer, then a filter that accepts a value only after STABLE_CYC consecutive equal samples.
REQ-013 SHALL treat the accepted code as held key; mid-transition bus values held shorter than STABLE_CYC cycles SHALL never be accepted.
REQ-014 SHALL run one FSM per player: IDLE, PRESS, HOLD_DLY, REPEAT.
REQ-015 IDLE -> PRESS when a mapped or esc code is accepted; PRESS lasts exactly one cycle and asserts the mapped bit (or o_esc).
REQ-016 PRESS -> HOLD_DLY for repeatable actions (down, left, right); otherwise PRESS -> IDLE-HELD, with no further pulses until the code changes.
REQ-017 HOLD_DLY: pulse after REPEAT_DELAY cycles counted from PRESS, then -> REPEAT; REPEAT: pulse every REPEAT_PERIOD cycles.
REQ-018 Accepted code 0 or unmapped in any state SHALL -> IDLE with no pulse; counter cleared.
REQ-019 Accepted change to a different mapped code in any state SHALL -> PRESS for the new code (new pulse, counter restarted).
REQ-020 Latency: a steady input change SHALL produce its press pulse exactly STABLE_CYC+3 cycles after the first i_clk edge sampling it.
REQ-021 At most one bit per o_pX_act SHALL be high in any cycle; o_esc SHALL be one pulse when both players press esc in the same cycle.
REQ-022 Repeat counters SHALL be 24 bits and SHALL saturate rather than wrap.

Reset
REQ-023 While i_rst_n is low: all outputs 0, synchronizers and filters 0, FSMs IDLE, counters 0.
REQ-024 A key held across reset release SHALL produce one press pulse once filtered, with no pulse during reset.

Configuration
REQ-025 With KEY_REPEAT_EN defined: auto-repeat per REQ-016/017.
REQ-026 Without KEY_REPEAT_EN: HOLD_DLY/REPEAT and their counters are absent; only press pulses are generated.

Structure
REQ-027 Package key_pkg SHALL hold the scan-code constants, the action-index constants and the FSM state enum.
REQ-028 Sub-module key_chan (synchronizer + filter + FSM + counter, parameterized by player code map) SHALL be instantiated twice; o_esc is the OR of both channel esc pulses.

Verification
REQ-029 P1 = 6B held 10 cycles, STABLE_CYC=4 -> o_p1_act=000100 for exactly one cycle, 7 cycles after change.
REQ-030 P1 = 72 held, REPEAT_DELAY=20, REPEAT_PERIOD=5 -> pulses on bit1 at t0, t0+20, t0+25, t0+30, ...
REQ-031 P2 = 12 held 100 cycles -> single bit4 pulse on o_p2_act; no repeat.
REQ-032 P1 bus glitch 00->7F for 2 cycles then 00 -> no pulse on any output.
REQ-033 P1 and P2 both = 76 in the same cycle -> one o_esc pulse; o_p1_act and o_p2_act stay 0.
REQ-034 Reset asserted mid-REPEAT -> outputs 0 immediately; key still held after release -> one press pulse STABLE_CYC+3 cycles later.
